// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the fetch next-PC generator and its branch target buffer.
package fetch_pc_unit_pkg;

    localparam int PC_W      = 14;
    localparam int BTB_IDX_W = 6;
    localparam int TAG_W     = PC_W - BTB_IDX_W;
    localparam int CNT_W     = 3;

    typedef logic [PC_W-1:0]      pc_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [BTB_IDX_W-1:0] btb_idx_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
        pc_t  target;
    } btb_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } fetch_state_e;

    // Word-address increment; wraps modulo 2^PC_W by construction.
    function automatic pc_t pc_inc(input pc_t p);
        return p + pc_t'(1);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus: predictor lookup, branch resolution, and predictor training.
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic stall;
    logic pred_taken;
    logic res_valid;
    pc_t  res_pc;
    logic res_taken;
    pc_t  res_target;
    logic res_pred_taken;
    pc_t  res_pred_target;

    pc_t  pc;
    logic fetch_valid;
    pc_t  pred_next;
    logic pred_dir;
    logic flush;
    logic upd_valid;
    pc_t  upd_pc;
    logic upd_taken;

    modport master (
        input  stall, pred_taken, res_valid, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        output pc, fetch_valid, pred_next, pred_dir, flush, upd_valid,
               upd_pc, upd_taken
    );

    modport slave (
        output stall, pred_taken, res_valid, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        input  pc, fetch_valid, pred_next, pred_dir, flush, upd_valid,
               upd_pc, upd_taken
    );

endinterface

// File: rtl/fetch_pc_unit_btb_direct.sv
// Direct-mapped BTB: combinational lookup, single write port, one-cycle valid clear.
module btb_direct
    import fetch_pc_unit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  pc_t  rd_pc,
    output logic hit,
    output pc_t  rd_target,
    input  logic we,
    input  pc_t  wr_pc,
    input  pc_t  wr_target
);

    localparam int ENTRIES = 1 << BTB_IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    tag_t               tag_q [ENTRIES];
    pc_t                tgt_q [ENTRIES];

    btb_idx_t   rd_idx, wr_idx;
    btb_entry_t rd_entry;

    assign rd_idx = rd_pc[BTB_IDX_W-1:0];
    assign wr_idx = wr_pc[BTB_IDX_W-1:0];

    // Reads see pre-edge contents, so a same-index write shows up next cycle.
    always_comb begin
        rd_entry.valid  = valid_q[rd_idx];
        rd_entry.tag    = tag_q[rd_idx];
        rd_entry.target = tgt_q[rd_idx];
    end

    assign hit       = rd_entry.valid && (rd_entry.tag == rd_pc[PC_W-1:BTB_IDX_W]);
    assign rd_target = rd_entry.target;

    always_comb begin
        valid_d = valid_q;
        if (we) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Payload needs no reset: a cleared valid bit hides stale contents.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx] <= wr_pc[PC_W-1:BTB_IDX_W];
            tgt_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch next-PC generator: BTB prediction, mispredict redirect with bubbles, predictor training.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter pc_t RESET_PC = '0,
    parameter int  BUBBLES  = 1
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_unit_if.master bus
);

    fetch_state_e     state_q, state_d;
    pc_t              pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             flush_q, flush_d;
    logic             upd_valid_q, upd_valid_d;
    pc_t              upd_pc_q, upd_pc_d;
    logic             upd_taken_q, upd_taken_d;

    logic btb_hit;
    pc_t  btb_target;
    logic pred_dir;
    pc_t  pred_next;
    logic mispredict;
    pc_t  correct_pc;

    btb_direct u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_pc     (pc_q),
        .hit       (btb_hit),
        .rd_target (btb_target),
        .we        (bus.res_valid & bus.res_taken),
        .wr_pc     (bus.res_pc),
        .wr_target (bus.res_target)
    );

    assign pred_dir  = bus.pred_taken & btb_hit;
    assign pred_next = pred_dir ? btb_target : pc_inc(pc_q);

    always_comb begin
        mispredict = 1'b0;
        correct_pc = bus.res_target;
        if (bus.res_valid) begin
            if (bus.res_taken &&
                (!bus.res_pred_taken || bus.res_pred_target != bus.res_target)) begin
                mispredict = 1'b1;
                correct_pc = bus.res_target;
            end else if (!bus.res_taken && bus.res_pred_taken) begin
                mispredict = 1'b1;
                correct_pc = pc_inc(bus.res_pc);
            end
        end
    end

    // A mispredict overrides both stall and any bubble already in progress.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (mispredict) begin
            pc_d    = correct_pc;
            cnt_d   = CNT_W'(BUBBLES);
            state_d = BUBBLE;
        end else begin
            case (state_q)
                RUN:    if (!bus.stall) pc_d = pred_next;
                BUBBLE: begin
                    if (cnt_q <= CNT_W'(1)) state_d = RUN;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = RUN;
            endcase
        end
        fetch_valid_d = (state_d == RUN);
        flush_d       = mispredict;
        upd_valid_d   = bus.res_valid;
        upd_pc_d      = bus.res_pc;
        upd_taken_d   = bus.res_taken;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.pred_next   = pred_next;
    assign bus.pred_dir    = pred_dir;
    assign bus.flush       = flush_q;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_pc      = upd_pc_q;
    assign bus.upd_taken   = upd_taken_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized checks of fetch_pc_unit against a behavioural fetch model.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    localparam int  BUBBLES = 3;
    localparam int  PCMOD   = 1 << PC_W;
    localparam int  NIDX    = 1 << BTB_IDX_W;
    localparam pc_t RST_PC  = 14'h0000;

    logic clk = 1'b0;
    logic reset;
    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_PC(RST_PC), .BUBBLES(BUBBLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Model: bubble cycles remaining, plus a BTB keyed by index holding the full branch PC.
    int m_pc = 0, m_left = 0;
    bit m_flush = 0, m_uv = 0, m_ut = 0;
    int m_upc = 0;
    bit m_bv [NIDX];
    int m_bpc[NIDX];
    int m_btg[NIDX];

    function automatic bit mdl_hit(input int p);
        return m_bv[p % NIDX] && (m_bpc[p % NIDX] == p);
    endfunction

    function automatic bit mdl_dir(input bit pt);
        return pt && mdl_hit(m_pc);
    endfunction

    function automatic int mdl_next(input bit pt);
        return mdl_dir(pt) ? m_btg[m_pc % NIDX] : (m_pc + 1) % PCMOD;
    endfunction

    task automatic idle_inputs();
        bus.stall = 0; bus.pred_taken = 0; bus.res_valid = 0; bus.res_pc = '0;
        bus.res_taken = 0; bus.res_target = '0; bus.res_pred_taken = 0;
        bus.res_pred_target = '0;
    endtask

    // One clock edge; the model consumes the same inputs the DUT sees at that edge.
    task automatic advance();
        bit rst, stl, pt, rv, rt, rpt, mis;
        int rpc, rtg, rptg, cpc, nxt, idx;
        rst = reset; stl = bus.stall; pt = bus.pred_taken; rv = bus.res_valid;
        rt = bus.res_taken; rpt = bus.res_pred_taken;
        rpc = int'(bus.res_pc); rtg = int'(bus.res_target); rptg = int'(bus.res_pred_target);
        nxt = mdl_next(pt);
        mis = 0; cpc = 0;
        if (rv && rt && (!rpt || rptg != rtg)) begin mis = 1; cpc = rtg; end
        else if (rv && !rt && rpt)             begin mis = 1; cpc = (rpc + 1) % PCMOD; end
        @(posedge clk);
        if (rst) begin
            m_pc = int'(RST_PC); m_left = 0; m_flush = 0; m_uv = 0; m_upc = 0; m_ut = 0;
            for (int i = 0; i < NIDX; i++) m_bv[i] = 0;
        end else begin
            m_flush = mis; m_uv = rv; m_upc = rpc; m_ut = rt;
            if (mis)             begin m_pc = cpc; m_left = BUBBLES; end
            else if (m_left > 0) m_left--;
            else if (!stl)       m_pc = nxt;
            if (rv && rt) begin
                idx = rpc % NIDX;
                m_bv[idx] = 1; m_bpc[idx] = rpc; m_btg[idx] = rtg;
            end
        end
        #1;
    endtask

    // Taken branch at rpc resolved against a not-taken prediction, then wait out the bubble.
    task automatic redirect_to(input int tgt, input int rpc);
        int guard;
        bus.res_valid = 1; bus.res_pc = pc_t'(rpc); bus.res_taken = 1;
        bus.res_target = pc_t'(tgt); bus.res_pred_taken = 0; bus.res_pred_target = '0;
        advance();
        bus.res_valid = 0; bus.res_taken = 0;
        guard = 0;
        while (m_left > 0 && guard < 20) begin advance(); guard++; end
        nvec++;
        if (guard >= 20) begin
            nerr++; $display("FAIL bubble_timeout: left=%0d want 0", m_left);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        advance(); advance();
        reset = 0;
        nvec += 6;
        if (bus.pc !== RST_PC)        begin nerr++; $display("FAIL rst_pc: got %0h want %0h", bus.pc, RST_PC); end
        if (bus.fetch_valid !== 1'b1) begin nerr++; $display("FAIL rst_fv: got %0b want 1", bus.fetch_valid); end
        if (bus.flush !== 1'b0)       begin nerr++; $display("FAIL rst_flush: got %0b want 0", bus.flush); end
        if (bus.upd_valid !== 1'b0)   begin nerr++; $display("FAIL rst_uv: got %0b want 0", bus.upd_valid); end
        if (bus.upd_pc !== '0)        begin nerr++; $display("FAIL rst_upc: got %0h want 0", bus.upd_pc); end
        if (bus.upd_taken !== 1'b0)   begin nerr++; $display("FAIL rst_ut: got %0b want 0", bus.upd_taken); end
        for (int i = 1; i <= 4; i++) begin
            advance();
            nvec += 3;
            if (bus.pc !== pc_t'(i)) begin nerr++; $display("FAIL seq_pc: got %0h want %0h", bus.pc, i); end
            if (bus.fetch_valid !== 1'b1 || bus.flush !== 1'b0) begin
                nerr++; $display("FAIL seq_fv_flush: got %0b/%0b want 1/0", bus.fetch_valid, bus.flush);
            end
            if (bus.upd_valid !== 1'b0) begin nerr++; $display("FAIL seq_uv: got %0b want 0", bus.upd_valid); end
        end
    endtask

    task automatic test_redirect_taken();
        bus.res_valid = 1; bus.res_pc = 14'h5; bus.res_taken = 1;
        bus.res_target = 14'h20; bus.res_pred_taken = 0;
        advance();
        idle_inputs();
        nvec += 5;
        if (bus.pc !== 14'h20)        begin nerr++; $display("FAIL redir_pc: got %0h want 20", bus.pc); end
        if (bus.flush !== 1'b1)       begin nerr++; $display("FAIL redir_flush: got %0b want 1", bus.flush); end
        if (bus.fetch_valid !== 1'b0) begin nerr++; $display("FAIL redir_fv: got %0b want 0", bus.fetch_valid); end
        if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 14'h5 || bus.upd_taken !== 1'b1) begin
            nerr++; $display("FAIL redir_upd: got %0b/%0h/%0b want 1/5/1", bus.upd_valid, bus.upd_pc, bus.upd_taken);
        end
        advance();
        if (bus.flush !== 1'b0) begin nerr++; $display("FAIL flush_pulse: got %0b want 0", bus.flush); end
        // fetch_valid stays low for exactly BUBBLES cycles after the redirect
        for (int i = 1; i < BUBBLES; i++) begin
            nvec++;
            if (bus.fetch_valid !== 1'b0 || bus.pc !== 14'h20) begin
                nerr++; $display("FAIL bubble_hold: got fv=%0b pc=%0h want 0/20", bus.fetch_valid, bus.pc);
            end
            advance();
        end
        nvec++;
        if (bus.fetch_valid !== 1'b1 || bus.pc !== 14'h20) begin
            nerr++; $display("FAIL bubble_end: got fv=%0b pc=%0h want 1/20", bus.fetch_valid, bus.pc);
        end
        redirect_to(5, 14'h100);
        bus.pred_taken = 1; #1;
        nvec += 2;
        if (bus.pred_dir !== 1'b1)   begin nerr++; $display("FAIL btb_dir: got %0b want 1", bus.pred_dir); end
        if (bus.pred_next !== 14'h20) begin nerr++; $display("FAIL btb_next: got %0h want 20", bus.pred_next); end
        bus.pred_taken = 0;
    endtask

    task automatic test_not_taken();
        bus.res_valid = 1; bus.res_pc = 14'h5; bus.res_taken = 0;
        bus.res_target = 14'h20; bus.res_pred_taken = 1; bus.res_pred_target = 14'h20;
        advance();
        idle_inputs();
        nvec += 2;
        if (bus.pc !== 14'h6)   begin nerr++; $display("FAIL nt_pc: got %0h want 6", bus.pc); end
        if (bus.flush !== 1'b1) begin nerr++; $display("FAIL nt_flush: got %0b want 1", bus.flush); end
        while (m_left > 0) advance();
        redirect_to(5, 14'h140);
        bus.pred_taken = 1; #1;
        nvec++;
        if (bus.pred_dir !== 1'b1 || bus.pred_next !== 14'h20) begin
            nerr++; $display("FAIL nt_btb_kept: got %0b/%0h want 1/20", bus.pred_dir, bus.pred_next);
        end
        bus.pred_taken = 0;
    endtask

    task automatic test_alias();
        redirect_to(14'h45, 14'h180);
        bus.pred_taken = 1; #1;
        nvec += 3;
        if (bus.pred_dir !== 1'b0)    begin nerr++; $display("FAIL alias_dir: got %0b want 0", bus.pred_dir); end
        if (bus.pred_next !== 14'h46) begin nerr++; $display("FAIL alias_next: got %0h want 46", bus.pred_next); end
        advance();
        if (bus.pc !== 14'h46) begin nerr++; $display("FAIL alias_pc: got %0h want 46", bus.pc); end
        bus.pred_taken = 0;
    endtask

    task automatic test_wrap_stall();
        redirect_to(14'h3FFF, 14'h1C0);
        advance();
        nvec++;
        if (bus.pc !== 14'h0000) begin nerr++; $display("FAIL wrap_pc: got %0h want 0", bus.pc); end
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            advance();
            nvec++;
            if (bus.pc !== 14'h0000 || bus.fetch_valid !== 1'b1) begin
                nerr++; $display("FAIL stall_hold: got pc=%0h fv=%0b want 0/1", bus.pc, bus.fetch_valid);
            end
        end
        bus.res_valid = 1; bus.res_pc = 14'h7; bus.res_taken = 1;
        bus.res_target = 14'h123; bus.res_pred_taken = 0;
        advance();
        idle_inputs();
        nvec++;
        if (bus.pc !== 14'h123 || bus.flush !== 1'b1) begin
            nerr++; $display("FAIL stall_redir: got pc=%0h flush=%0b want 123/1", bus.pc, bus.flush);
        end
    endtask

    task automatic test_reset_bubble();
        advance();
        reset = 1;
        advance();
        reset = 0;
        nvec++;
        if (bus.pc !== RST_PC || bus.fetch_valid !== 1'b1 || bus.flush !== 1'b0) begin
            nerr++; $display("FAIL rst_bubble: got pc=%0h fv=%0b fl=%0b want 0/1/0", bus.pc, bus.fetch_valid, bus.flush);
        end
        bus.pred_taken = 1;
        for (int i = 0; i <= 5; i++) begin
            #1;
            nvec += 2;
            if (bus.pc !== pc_t'(i))   begin nerr++; $display("FAIL rst_walk_pc: got %0h want %0h", bus.pc, i); end
            if (bus.pred_dir !== 1'b0) begin nerr++; $display("FAIL rst_btb_miss: pc=%0h got %0b want 0", bus.pc, bus.pred_dir); end
            advance();
        end
        bus.pred_taken = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(99) < 2);
            bus.stall      = ($urandom_range(99) < 20);
            bus.pred_taken = $urandom_range(1);
            bus.res_valid  = ($urandom_range(99) < 30);
            bus.res_pc     = pc_t'($urandom_range(255));
            bus.res_taken  = $urandom_range(1);
            bus.res_target = pc_t'($urandom_range(255));
            bus.res_pred_taken  = $urandom_range(1);
            bus.res_pred_target = $urandom_range(1) ? bus.res_target : pc_t'($urandom_range(255));
            if ($urandom_range(99) < 3) bus.res_target = 14'h3FFF;
            #1;
            nvec += 2;
            if (bus.pred_dir !== mdl_dir(bus.pred_taken)) begin
                nerr++; $display("FAIL rnd_dir: pc=%0h got %0b want %0b", bus.pc, bus.pred_dir, mdl_dir(bus.pred_taken));
            end
            if (bus.pred_next !== pc_t'(mdl_next(bus.pred_taken))) begin
                nerr++; $display("FAIL rnd_next: pc=%0h got %0h want %0h", bus.pc, bus.pred_next, mdl_next(bus.pred_taken));
            end
            advance();
            nvec += 4;
            if (bus.pc !== pc_t'(m_pc)) begin nerr++; $display("FAIL rnd_pc: got %0h want %0h", bus.pc, m_pc); end
            if (bus.fetch_valid !== (m_left == 0)) begin
                nerr++; $display("FAIL rnd_fv: got %0b want %0b", bus.fetch_valid, m_left == 0);
            end
            if (bus.flush !== m_flush) begin nerr++; $display("FAIL rnd_flush: got %0b want %0b", bus.flush, m_flush); end
            if (bus.upd_valid !== m_uv || bus.upd_pc !== pc_t'(m_upc) || bus.upd_taken !== m_ut) begin
                nerr++; $display("FAIL rnd_upd: got %0b/%0h/%0b want %0b/%0h/%0b",
                                 bus.upd_valid, bus.upd_pc, bus.upd_taken, m_uv, m_upc, m_ut);
            end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        #1;
        test_reset();
        test_redirect_taken();
        test_not_taken();
        test_alias();
        test_wrap_stall();
        test_reset_bubble();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage next-PC generator that sits directly upstream of the 2-bit branch predictor.
- Drives the 14-bit word-addressed fetch PC that indexes the predictor and consumes its taken/not-taken bit.
- Holds a direct-mapped branch target buffer (BTB) that supplies predicted targets.
- Detects mispredictions at branch resolution, redirects fetch, pulses flush, and forwards registered training updates (PC, taken) back to the predictor.

Parameters:
- PC_W, 14, PC width in words; matches the predictor index width.
- BTB_IDX_W, 6, log2 of BTB entry count (64 entries).
- RESET_PC, 14'h0000, fetch PC loaded on reset.
- BUBBLES, 1, cycles fetch_valid is held low after a redirect (1..7).

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold pc; no new fetch
- pred_taken  in  1  predictor output for current pc (combinational in same cycle)
- res_valid  in  1  a branch resolved this cycle
- res_pc  in  PC_W  PC of the resolved branch
- res_taken  in  1  actual outcome
- res_target  in  PC_W  actual taken target
- res_pred_taken  in  1  prediction carried down the pipeline with this branch
- res_pred_target  in  PC_W  predicted next PC carried with this branch
- pc  out  PC_W  current fetch PC (to imem and predictor index)
- fetch_valid  out  1  pc is a valid fetch
- pred_next  out  PC_W  predicted next PC for the current fetch, carried down the pipeline
- pred_dir  out  1  pred_taken & btb_hit, carried down the pipeline
- flush  out  1  one-cycle pulse; kill younger instructions
- upd_valid  out  1  predictor training strobe
- upd_pc  out  PC_W  training PC (predictor "beforepc")
- upd_taken  out  1  training outcome (predictor "pcsrc")

Behaviour:
- Reset (synchronous, wins over everything):
  - pc = RESET_PC; state = RUN; fetch_valid = 1.
  - flush = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0.
  - All BTB valid bits cleared in one cycle.
  - Reset asserted mid-BUBBLE returns to RUN at RESET_PC.
- BTB: entry = {valid, tag[PC_W-BTB_IDX_W], target[PC_W]}; index = pc[BTB_IDX_W-1:0].
  - btb_hit = valid & (tag == pc upper bits).
  - Combinational read.
- Prediction (combinational):
  - pred_dir = pred_taken & btb_hit.
  - pred_next = pred_dir ? target : pc+1.
  - pc+1 wraps 14'h3FFF -> 14'h0000.
- Mispredict = res_valid & one of:
  - res_taken & (!res_pred_taken | res_pred_target != res_target) -> correct PC = res_target.
  - !res_taken & res_pred_taken -> correct PC = res_pc+1 (wraps).
- FSM states RUN and BUBBLE.
  - RUN, mispredict: pc <= correct PC; flush <= 1 for exactly one cycle; bubble counter <= BUBBLES; state -> BUBBLE.
  - RUN, no mispredict: if !stall then pc <= pred_next, else pc holds.
  - BUBBLE: fetch_valid = 0; pc holds; counter decrements each cycle; state -> RUN when the counter reaches 1.
  - BUBBLE, new mispredict: re-redirect, flush again, counter reloaded.
- Priority: reset > mispredict > stall > normal advance. A mispredict during stall still redirects.
- BTB write, on res_valid & res_taken (independent of mispredict): entry[res_pc idx] <= {1, res_pc tag, res_target}. Not-taken resolution leaves the BTB unchanged.
- Read/write same index, same cycle: the read returns the old contents (write visible next cycle).
- Training:
  - upd_valid <= res_valid, upd_pc <= res_pc, upd_taken <= res_taken.
  - Registered, 1-cycle latency, every resolution including correct ones.
  - upd_valid = 0 when res_valid = 0.
- Widths: all PC arithmetic is modulo 2^PC_W; no carry-out.

Decomposition:
- Shared package (cpu_pkg):
  - PC_W; pc_t typedef.
  - btb_entry_t struct {valid, tag, target}.
  - fetch_state_e enum {RUN, BUBBLE}.
- One sub-module is natural: btb_direct (storage, hit compare, write port), instantiated by fetch_pc_unit.

Test Plan:
- Reset then 4 cycles, no stall, pred_taken = 0 -> pc 0,1,2,3,4; fetch_valid = 1; flush = 0; upd_valid = 0.
- Resolve pc = 5 taken, target = 0x20, res_pred_taken = 0 -> next cycle pc = 0x20, flush = 1 for one cycle, fetch_valid = 0 for 1 cycle, upd_pc = 5, upd_taken = 1. Later, pc reaches 5 with pred_taken = 1 -> pred_dir = 1, pred_next = 0x20.
- Resolve pc = 5 not taken, res_pred_taken = 1 -> pc = 6, flush pulse; BTB entry 5 still valid.
- Aliasing: BTB holds pc 0x005; fetch pc 0x045 (same index, different tag) with pred_taken = 1 -> pred_dir = 0, pred_next = 0x046.
- pc = 0x3FFF, no branch -> next pc = 0x0000. Stall high 3 cycles -> pc holds. Mispredict during stall -> redirect still taken.
- Reset asserted in BUBBLE (BUBBLES = 3, mid-count) -> next cycle pc = RESET_PC, fetch_valid = 1, all BTB lookups miss.
